// File: rtl/rv_pkg.sv
// Shared RV32I pipeline types: branch funct3 encodings, EX/MEM entry layout, branch resolve.
// EX_MISALIGN_EN adds a faulting-target field to the entry.
package rv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RADDR = 5;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef struct packed {
`ifdef EX_MISALIGN_EN
        logic [XLEN-1:0]  tval;
`endif
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  store_data;
        logic [2:0]       funct3;
        logic [RADDR-1:0] rd;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             exc;
    } exmem_entry_t;

    function automatic logic br_taken(input logic [2:0] funct3, input logic zero,
                                      input logic lt, input logic ltu);
        logic taken;
        case (funct3)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_BLT:  taken = lt;
            BR_BGE:  taken = ~lt;
            BR_BLTU: taken = ltu;
            BR_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Generic 2-entry valid/ready queue with registered in_ready, flush and synchronous reset.
module skid_buffer2 #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
);

    logic [1:0]       count_q, count_d;
    logic [Width-1:0] head_q, head_d, tail_q, tail_d;
    logic             ready_q;
    logic             push, pop;

    assign push = in_valid & ready_q & ~flush;
    assign pop  = (count_q != 2'd0) & out_ready & ~flush;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = in_data;
                    else                 tail_d = in_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                // Only reachable at count 1: push needs a free slot, pop needs an entry.
                2'b11: head_d = in_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            ready_q <= 1'b1;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM boundary: branch/jump resolve, registered one-cycle redirect, 2-deep skid queue to MEM.
// EX_MISALIGN_EN adds exc_valid/exc_tval and suppresses redirects to misaligned targets.
module ex_mem_stage
    import rv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             alu_ltu,
    input  logic [2:0]       funct3,
    input  logic             is_branch,
    input  logic             is_jump,
    input  logic [XLEN-1:0]  pc_target,
    input  logic [XLEN-1:0]  pc_plus4,
    input  logic [XLEN-1:0]  store_data,
    input  logic [RADDR-1:0] rd,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [XLEN-1:0]  out_store_data,
    output logic [2:0]       out_funct3,
    output logic [RADDR-1:0] out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
`ifdef EX_MISALIGN_EN
    output logic             exc_valid,
    output logic [XLEN-1:0]  exc_tval,
`endif
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc
);

    logic         taken, misaligned, accept;
    logic         redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    exmem_entry_t entry_in, entry_out;

    assign taken = is_jump | (is_branch & br_taken(funct3, alu_zero, alu_lt, alu_ltu));
`ifdef EX_MISALIGN_EN
    assign misaligned = taken & (pc_target[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    assign accept = in_valid & in_ready & ~flush;

    always_comb begin
        entry_in            = '0;
`ifdef EX_MISALIGN_EN
        entry_in.tval       = pc_target;
`endif
        entry_in.result     = is_jump ? pc_plus4 : alu_result;
        entry_in.store_data = store_data;
        entry_in.funct3     = funct3;
        entry_in.rd         = rd;
        // A faulting instruction must have no architectural side effects downstream.
        entry_in.reg_write  = reg_write & ~is_branch & ~misaligned;
        entry_in.mem_read   = mem_read & ~misaligned;
        entry_in.mem_write  = mem_write & ~misaligned;
        entry_in.exc        = misaligned;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= accept & taken & ~misaligned;
            if (accept & taken & ~misaligned) redirect_pc_q <= pc_target;
        end
    end

    skid_buffer2 #(
        .Width($bits(exmem_entry_t))
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (entry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (entry_out)
    );

    assign out_result     = entry_out.result;
    assign out_store_data = entry_out.store_data;
    assign out_funct3     = entry_out.funct3;
    assign out_rd         = entry_out.rd;
    assign out_reg_write  = entry_out.reg_write;
    assign out_mem_read   = entry_out.mem_read;
    assign out_mem_write  = entry_out.mem_write;
`ifdef EX_MISALIGN_EN
    assign exc_valid      = out_valid & entry_out.exc;
    assign exc_tval       = entry_out.tval;
`endif
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed RV32I cases followed by randomized traffic.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [31:0] alu_result, pc_target, pc_plus4, store_data;
    logic        alu_zero, alu_lt, alu_ltu;
    logic [2:0]  funct3;
    logic        is_branch, is_jump;
    logic [4:0]  rd;
    logic        reg_write, mem_read, mem_write;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_store_data;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_mem_read, out_mem_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef EX_MISALIGN_EN
    logic        exc_valid;
    logic [31:0] exc_tval;
`endif

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .alu_lt         (alu_lt),
        .alu_ltu        (alu_ltu),
        .funct3         (funct3),
        .is_branch      (is_branch),
        .is_jump        (is_jump),
        .pc_target      (pc_target),
        .pc_plus4       (pc_plus4),
        .store_data     (store_data),
        .rd             (rd),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_funct3     (out_funct3),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
`ifdef EX_MISALIGN_EN
        .exc_valid      (exc_valid),
        .exc_tval       (exc_tval),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        exc;
        logic [31:0] tval;
    } ent_t;

    ent_t        sb[$];
    int          cnt = 0;
    logic        exp_rv = 1'b0;
    logic [31:0] exp_rpc = '0;
    logic        last_acc = 1'b0;
    logic        done = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_taken(input logic [2:0] f, input logic z, input logic l,
                                        input logic lu);
        case (f)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: advance on every rising edge using the inputs applied for that edge.
    task automatic tick();
        logic tk, mis;
        ent_t e;
        @(posedge clk);
        last_acc = 1'b0;
        if (!rst_n) begin
            cnt = 0; sb.delete(); exp_rv = 1'b0; exp_rpc = '0;
        end else if (flush) begin
            cnt = 0; sb.delete(); exp_rv = 1'b0;
        end else begin
            int pop;
            pop = (cnt > 0 && out_ready) ? 1 : 0;
            exp_rv = 1'b0;
            if (in_valid && cnt < 2) begin
                last_acc = 1'b1;
                tk = is_jump || (is_branch && cond_taken(funct3, alu_zero, alu_lt, alu_ltu));
`ifdef EX_MISALIGN_EN
                mis = tk && (pc_target % 4 != 0);
`else
                mis = 1'b0;
`endif
                if (tk && !mis) begin
                    exp_rv = 1'b1;
                    exp_rpc = pc_target;
                end
                e.result     = is_jump ? pc_plus4 : alu_result;
                e.store_data = store_data;
                e.funct3     = funct3;
                e.rd         = rd;
                e.reg_write  = reg_write && !is_branch && !mis;
                e.mem_read   = mem_read && !mis;
                e.mem_write  = mem_write && !mis;
                e.exc        = mis;
                e.tval       = pc_target;
                sb.push_back(e);
                cnt = cnt + 1;
            end
            cnt = cnt - pop;
        end
        #1;
    endtask

    // Monitor: compare DUT outputs against the model; consume the head on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                check("in_ready", 32'(in_ready), 32'(cnt < 2));
                check("out_valid", 32'(out_valid), 32'(cnt > 0));
                check("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
                check("redirect_pc", redirect_pc, exp_rpc);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("scoreboard_empty", 32'(out_valid), 32'd0);
                    end else begin
                        check("out_result", out_result, sb[0].result);
                        check("out_store_data", out_store_data, sb[0].store_data);
                        check("out_funct3", 32'(out_funct3), 32'(sb[0].funct3));
                        check("out_rd", 32'(out_rd), 32'(sb[0].rd));
                        check("out_reg_write", 32'(out_reg_write), 32'(sb[0].reg_write));
                        check("out_mem_read", 32'(out_mem_read), 32'(sb[0].mem_read));
                        check("out_mem_write", 32'(out_mem_write), 32'(sb[0].mem_write));
`ifdef EX_MISALIGN_EN
                        check("exc_valid", 32'(exc_valid), 32'(sb[0].exc));
                        if (sb[0].exc) check("exc_tval", exc_tval, sb[0].tval);
`endif
                        if (out_ready && rst_n && !flush) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic idle();
        in_valid = 0; flush = 0; alu_result = '0; alu_zero = 0; alu_lt = 0; alu_ltu = 0;
        funct3 = '0; is_branch = 0; is_jump = 0; pc_target = '0; pc_plus4 = '0;
        store_data = '0; rd = '0; reg_write = 0; mem_read = 0; mem_write = 0;
    endtask

    // Hold the current instruction on the input until the model accepts it.
    task automatic send(input string name);
        int n;
        in_valid = 1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) check({name, "_accept_timeout"}, 32'd0, 32'd1);
        idle();
    endtask

    task automatic alu_op(input logic [31:0] res);
        idle();
        alu_result = res; rd = 5'd3; reg_write = 1;
    endtask

    task automatic branch(input logic [2:0] f, input logic z, input logic l, input logic lu,
                          input logic [31:0] tgt);
        idle();
        is_branch = 1; funct3 = f; alu_zero = z; alu_lt = l; alu_ltu = lu;
        pc_target = tgt; reg_write = 1; rd = 5'd7;
    endtask

    initial begin
        idle();
        out_ready = 1;
        rst_n = 0;
        in_valid = 1;
        tick();
        tick();
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_reg_write", 32'(out_reg_write), 32'd0);
        rst_n = 1;
        idle();
        tick();

        // Branch resolution cases.
        branch(3'b000, 1, 0, 0, 32'h100); send("beq");
        tick(); tick();
        branch(3'b111, 0, 0, 1, 32'h200); send("bgeu");
        branch(3'b100, 0, 1, 0, 32'h80);  send("blt");
        branch(3'b010, 1, 1, 1, 32'h300); send("f010");
        branch(3'b011, 0, 0, 0, 32'h304); send("f011");
        branch(3'b001, 0, 0, 0, 32'h308); send("bne");
        idle(); is_jump = 1; pc_plus4 = 32'h24; rd = 5'd1; reg_write = 1; pc_target = 32'h400;
        send("jal");
        tick(); tick();

        // Backpressure: third instruction must wait for a freed slot.
        out_ready = 0;
        alu_op(32'd1); send("add1");
        alu_op(32'd2); send("add2");
        alu_op(32'd3); in_valid = 1;
        tick(); tick();
        out_ready = 1;
        send("add3");
        tick(); tick(); tick();

        // Flush with a full queue and a taken branch arriving.
        out_ready = 0;
        alu_op(32'd5); send("f1");
        alu_op(32'd6); send("f2");
        branch(3'b000, 1, 0, 0, 32'h500); in_valid = 1; flush = 1;
        tick();
        idle();
        out_ready = 1;
        tick();

`ifdef EX_MISALIGN_EN
        idle(); is_jump = 1; pc_target = 32'h102; pc_plus4 = 32'h8; rd = 5'd1; reg_write = 1;
        send("jalr_mis");
        tick(); tick();
`endif

        // Randomized traffic with occasional flush and one mid-run reset.
        for (int i = 0; i < 600; i++) begin
            idle();
            in_valid   = ($urandom_range(0, 9) < 6);
            out_ready  = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 29) == 0);
            rst_n      = (i != 300);
            alu_result = $urandom;
            alu_zero   = $urandom_range(0, 1);
            alu_lt     = $urandom_range(0, 1);
            alu_ltu    = $urandom_range(0, 1);
            funct3     = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: is_branch = 1;
                1: is_jump = 1;
                default: ;
            endcase
            pc_target  = $urandom;
            if ($urandom_range(0, 1) == 1) pc_target[1:0] = 2'b00;
            pc_plus4   = $urandom;
            store_data = $urandom;
            rd         = 5'($urandom);
            reg_write  = $urandom_range(0, 1);
            mem_read   = $urandom_range(0, 1);
            mem_write  = $urandom_range(0, 1);
            tick();
        end
        idle();
        rst_n = 1;
        out_ready = 1;
        tick(); tick(); tick();
        @(negedge clk);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
